// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues credit-limited fetches and
// buffers returned words for decode; a redirect flushes buffered and in-flight work.
module instr_fetch_unit #(
  parameter int              PC_W     = 9,
  parameter int              INS_W    = 32,
  parameter int              DEPTH    = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req_valid,
  output logic [PC_W-1:0]  imem_req_addr,
  input  logic             imem_req_ready,
  input  logic             imem_rsp_valid,
  input  logic [INS_W-1:0] imem_rsp_data,
  input  logic             redirect,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [INS_W-1:0] inst,
  output logic [PC_W-1:0]  inst_pc,
  output logic [6:0]       opcode
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    outstanding_q, outstanding_d;
  logic [CW-1:0]    drop_q, drop_d;
  logic [PW-1:0]    buf_head_q, buf_head_d;
  logic [PW-1:0]    buf_tail_q, buf_tail_d;
  logic [PW-1:0]    tag_head_q, tag_head_d;
  logic [PW-1:0]    tag_tail_q, tag_tail_d;
  logic [INS_W-1:0] buf_inst_q [DEPTH];
  logic [PC_W-1:0]  buf_pc_q   [DEPTH];
  logic [PC_W-1:0]  tag_q      [DEPTH];

  logic          pop, accept, rsp, rsp_keep, push;
  logic [CW:0]   inflight;
  logic          unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];

  assign inst_valid    = (count_q != '0);
  assign inst          = inst_valid ? buf_inst_q[buf_head_q] : '0;
  assign inst_pc       = inst_valid ? buf_pc_q[buf_head_q] : '0;
  assign opcode        = inst_valid ? buf_inst_q[buf_head_q][6:0] : 7'b0000000;
  assign imem_req_addr = fetch_pc_q;

  // Credit counts outstanding plus buffered words, less the one leaving this cycle.
  always_comb begin
    pop            = inst_valid && inst_ready;
    inflight       = {1'b0, outstanding_q} + {1'b0, count_q} - (CW+1)'(pop);
    imem_req_valid = !reset && (inflight < (CW+1)'(DEPTH));
    accept         = imem_req_valid && imem_req_ready;
    rsp            = imem_rsp_valid && (outstanding_q != '0);
    rsp_keep       = rsp && (drop_q == '0);
    push           = rsp_keep && !redirect;

    outstanding_d  = outstanding_q + CW'(accept) - CW'(rsp);
    tag_tail_d     = accept ? ptrInc(tag_tail_q) : tag_tail_q;
    tag_head_d     = rsp ? ptrInc(tag_head_q) : tag_head_q;

    fetch_pc_d     = accept ? fetch_pc_q + PC_W'(4) : fetch_pc_q;
    drop_d         = drop_q - CW'(rsp && !rsp_keep);
    count_d        = count_q + CW'(push) - CW'(pop);
    buf_head_d     = pop ? ptrInc(buf_head_q) : buf_head_q;
    buf_tail_d     = push ? ptrInc(buf_tail_q) : buf_tail_q;

    // Everything still in flight after this cycle belongs to the old path.
    if (redirect) begin
      fetch_pc_d = {redirect_pc[PC_W-1:2], 2'b00};
      drop_d     = outstanding_d;
      count_d    = '0;
      buf_head_d = '0;
      buf_tail_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
      buf_head_q    <= '0;
      buf_tail_q    <= '0;
      tag_head_q    <= '0;
      tag_tail_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_inst_q[i] <= '0;
        buf_pc_q[i]   <= '0;
        tag_q[i]      <= '0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      buf_head_q    <= buf_head_d;
      buf_tail_q    <= buf_tail_d;
      tag_head_q    <= tag_head_d;
      tag_tail_q    <= tag_tail_d;
      if (accept) tag_q[tag_tail_q] <= fetch_pc_q;
      if (push) begin
        buf_inst_q[buf_tail_q] <= imem_rsp_data;
        buf_pc_q[buf_tail_q]   <= tag_q[tag_head_q];
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a one-cycle in-order memory model
// whose responses can be held back to build up outstanding fetches.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic [8:0]  imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [8:0]  redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [8:0]  inst_pc;
  logic [6:0]  opcode;

  logic        rspHold;
  logic [8:0]  pend [$];
  int          checkCount  = 0;
  int          errorCount  = 0;
  int          acceptCount = 0;
  int          acceptBase;

  instr_fetch_unit #(
    .PC_W(9), .INS_W(32), .DEPTH(2), .RESET_PC(9'h000)
  ) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .opcode(opcode)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memData(input logic [8:0] a);
    if (a == 9'h100) return 32'h0000_0013;
    return {16'hC0DE, 7'h00, a};
  endfunction

  // Memory answers each accepted request in order, one cycle later unless held.
  always @(posedge clk) begin
    if (reset) begin
      pend.delete();
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= '0;
    end else begin
      if (imem_rsp_valid && pend.size() > 0) void'(pend.pop_front());
      if (imem_req_valid && imem_req_ready) begin
        pend.push_back(imem_req_addr);
        acceptCount++;
      end
      if (!rspHold && pend.size() > 0) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= memData(pend[0]);
      end else begin
        imem_rsp_valid <= 1'b0;
        imem_rsp_data  <= '0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic rdy,
                               input logic redir, input logic [8:0] rpc);
    @(negedge clk);
    reset       = rst;
    inst_ready  = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    #1;
  endtask

  initial begin
    reset = 1'b1; inst_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; rspHold = 1'b0;

    // Reset with a redirect asserted: the redirect must be ignored.
    applyStimulus(1'b1, 1'b1, 1'b1, 9'h080);
    applyStimulus(1'b1, 1'b1, 1'b1, 9'h080);
    checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("rst_inst_valid", 32'(inst_valid), 32'd0);
    checkOutput("rst_opcode", 32'(opcode), 32'd0);
    checkOutput("rst_inst", inst, 32'd0);
    checkOutput("rst_inst_pc", 32'(inst_pc), 32'd0);

    $display("[TB] streaming from reset");
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 9'h000);
      checkOutput("stream_req_valid", 32'(imem_req_valid), 32'd1);
      checkOutput("stream_req_addr", 32'(imem_req_addr), 32'(4 * k));
      if (k < 2) checkOutput("stream_inst_valid_lo", 32'(inst_valid), 32'd0);
      else begin
        checkOutput("stream_inst_valid", 32'(inst_valid), 32'd1);
        checkOutput("stream_inst_pc", 32'(inst_pc), 32'(4 * (k - 2)));
        checkOutput("stream_inst", inst, memData(9'(4 * (k - 2))));
      end
    end

    $display("[TB] mid-run reset then decode stall");
    applyStimulus(1'b1, 1'b0, 1'b0, 9'h000);
    checkOutput("midrst_req_valid", 32'(imem_req_valid), 32'd0);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 9'h000);
      if (k == 0) begin
        acceptBase = acceptCount;
        checkOutput("midrst_inst_valid", 32'(inst_valid), 32'd0);
        checkOutput("midrst_req_addr", 32'(imem_req_addr), 32'h000);
      end
    end
    checkOutput("stall_accepts", 32'(acceptCount - acceptBase), 32'd2);
    checkOutput("stall_req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("stall_inst_valid", 32'(inst_valid), 32'd1);
    checkOutput("stall_inst_pc", 32'(inst_pc), 32'h000);
    applyStimulus(1'b0, 1'b1, 1'b0, 9'h000);
    checkOutput("drain_req_addr0", 32'(imem_req_addr), 32'h008);
    checkOutput("drain_req_valid0", 32'(imem_req_valid), 32'd1);
    checkOutput("drain_pc0", 32'(inst_pc), 32'h000);
    applyStimulus(1'b0, 1'b1, 1'b0, 9'h000);
    checkOutput("drain_req_addr1", 32'(imem_req_addr), 32'h00C);
    checkOutput("drain_pc1", 32'(inst_pc), 32'h004);
    applyStimulus(1'b0, 1'b1, 1'b0, 9'h000);
    checkOutput("drain_valid2", 32'(inst_valid), 32'd1);
    checkOutput("drain_pc2", 32'(inst_pc), 32'h008);

    $display("[TB] redirect with two fetches outstanding");
    applyStimulus(1'b1, 1'b1, 1'b0, 9'h000);
    rspHold = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 9'h000);
    checkOutput("out2_req_addr0", 32'(imem_req_addr), 32'h000);
    applyStimulus(1'b0, 1'b1, 1'b0, 9'h000);
    checkOutput("out2_req_addr1", 32'(imem_req_addr), 32'h004);
    checkOutput("out2_req_valid1", 32'(imem_req_valid), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 9'h043);
    rspHold = 1'b0;
    checkOutput("out2_credit_full", 32'(imem_req_valid), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 9'h000);
    checkOutput("redir_req_valid_r1", 32'(imem_req_valid), 32'd0);
    checkOutput("redir_inst_valid_r1", 32'(inst_valid), 32'd0);
    checkOutput("redir_opcode_idle", 32'(opcode), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 9'h000);
    checkOutput("redir_req_valid_r2", 32'(imem_req_valid), 32'd1);
    checkOutput("redir_req_addr_r2", 32'(imem_req_addr), 32'h040);
    checkOutput("redir_inst_valid_r2", 32'(inst_valid), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 9'h000);
    checkOutput("redir_req_addr_r3", 32'(imem_req_addr), 32'h044);
    checkOutput("redir_inst_valid_r3", 32'(inst_valid), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 9'h000);
    checkOutput("redir_inst_valid_r4", 32'(inst_valid), 32'd1);
    checkOutput("redir_inst_pc_r4", 32'(inst_pc), 32'h040);
    checkOutput("redir_inst_r4", inst, memData(9'h040));

    $display("[TB] redirect coinciding with accept and response");
    applyStimulus(1'b0, 1'b1, 1'b1, 9'h100);
    checkOutput("coin_req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("coin_rsp_valid", 32'(imem_rsp_valid), 32'd1);
    checkOutput("coin_inst_pc", 32'(inst_pc), 32'h044);
    applyStimulus(1'b0, 1'b1, 1'b0, 9'h000);
    checkOutput("coin_inst_valid_r1", 32'(inst_valid), 32'd0);
    checkOutput("coin_req_addr_r1", 32'(imem_req_addr), 32'h100);
    checkOutput("coin_req_valid_r1", 32'(imem_req_valid), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 9'h000);
    checkOutput("coin_inst_valid_r2", 32'(inst_valid), 32'd0);
    checkOutput("coin_req_addr_r2", 32'(imem_req_addr), 32'h104);
    applyStimulus(1'b0, 1'b1, 1'b0, 9'h000);
    checkOutput("coin_inst_valid_r3", 32'(inst_valid), 32'd1);
    checkOutput("coin_inst_pc_r3", 32'(inst_pc), 32'h100);
    checkOutput("coin_inst_r3", inst, 32'h0000_0013);
    checkOutput("coin_opcode_r3", 32'(opcode), 32'h13);

    $display("[TB] wrap-around at top of PC space");
    applyStimulus(1'b0, 1'b1, 1'b1, 9'h1FD);
    checkOutput("wrap_inst_pc_r0", 32'(inst_pc), 32'h104);
    checkOutput("wrap_opcode_r0", 32'(opcode), 32'h04);
    applyStimulus(1'b0, 1'b1, 1'b0, 9'h000);
    checkOutput("wrap_req_addr_r1", 32'(imem_req_addr), 32'h1FC);
    checkOutput("wrap_inst_valid_r1", 32'(inst_valid), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 9'h000);
    checkOutput("wrap_req_addr_r2", 32'(imem_req_addr), 32'h000);
    checkOutput("wrap_inst_valid_r2", 32'(inst_valid), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 9'h000);
    checkOutput("wrap_inst_pc_r3", 32'(inst_pc), 32'h1FC);
    checkOutput("wrap_inst_r3", inst, memData(9'h1FC));
    checkOutput("wrap_req_addr_r3", 32'(imem_req_addr), 32'h004);
    applyStimulus(1'b0, 1'b1, 1'b0, 9'h000);
    checkOutput("wrap_inst_pc_r4", 32'(inst_pc), 32'h000);
    checkOutput("wrap_inst_r4", inst, memData(9'h000));

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
